// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg
// Shared definitions for the ultrasonic ranging front end:
//   - state_t     : sequencer state encoding (also exported on the debug port)
//   - DEF_*       : default timing constants for a 50 MHz system clock
//   - sat_inc8    : saturating 8-bit increment used by status counters
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    TRIG      = 3'd2,
    WAIT_RISE = 3'd3,
    WAIT_FALL = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  // 10 us trigger, 30 ms echo window, 60 ms shot period at 50 MHz.
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;
  localparam int DEF_PERIOD_CYCLES  = 3000000;
  localparam int DEF_CNT_WIDTH      = 22;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// echo_sync_edge
// Two-flop synchroniser for an asynchronous sensor line, followed by one
// delay register used for edge detection.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_async    : raw asynchronous input
//   o_sync     : synchronised level (2 cycles after i_async)
//   o_rise     : high for one cycle when o_sync goes 0->1
//   o_fall     : high for one cycle when o_sync goes 1->0
module echo_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_sync_d;
  assign o_fall = ~r_sync & r_sync_d;

endmodule

// File: rtl/ultrasonic_trigger_sequencer.sv
// ultrasonic_trigger_sequencer
// Fires the ultrasonic trigger on a fixed period, clears the downstream
// pulse timer before each shot, and watches the synchronised echo for a
// complete pulse or a timeout.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   enable        : run periodic shots while high; dropping it mid-shot aborts
//   echo_in       : raw asynchronous echo from the sensor
//   trigger_out   : sensor trigger pulse (TRIG_CYCLES wide)
//   echo_sync     : synchronised echo for the pulse timer
//   timer_reset   : clear for the pulse timer (high in IDLE and CLEAR)
//   busy          : high in any state other than IDLE
//   meas_done     : one-cycle pulse, echo fell (valid measurement)
//   timeout       : one-cycle pulse, shot lost
//   shot_count    : completed shots, wraps
//   timeout_count : timeouts, saturates at 255
//   dbg_state     : current state_t encoding
module ultrasonic_trigger_sequencer
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       echo_in,
  output logic       trigger_out,
  output logic       echo_sync,
  output logic       timer_reset,
  output logic       busy,
  output logic       meas_done,
  output logic       timeout,
  output logic [7:0] shot_count,
  output logic [7:0] timeout_count,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_WIDTH-1:0] TRIG_LAST   = CNT_WIDTH'(TRIG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(PERIOD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_done_evt;
  logic                 w_timeout_evt;
  logic                 w_trigger_nx;
  logic                 w_timer_reset_nx;
  logic                 w_busy_nx;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_sync;
  logic [CNT_WIDTH-1:0] r_period_cnt;
  logic [CNT_WIDTH-1:0] r_trig_cnt;
  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic                 r_trigger;
  logic                 r_timer_reset;
  logic                 r_busy;
  logic                 r_meas_done;
  logic                 r_timeout;
  logic [7:0]           r_shot_count;
  logic [7:0]           r_timeout_count;

  echo_sync_edge u_echo (
    .clk     (clk),
    .reset   (reset),
    .i_async (echo_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Next-state logic. Losing enable in an active shot phase beats every
  // other condition so an abort never emits a done/timeout pulse.
  always_comb begin
    w_next_state  = r_state;
    w_done_evt    = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      IDLE:      if (enable) w_next_state = CLEAR;
      CLEAR:     w_next_state = TRIG;
      TRIG: begin
        if (!enable)                      w_next_state = IDLE;
        else if (r_trig_cnt == TRIG_LAST) w_next_state = WAIT_RISE;
      end
      WAIT_RISE: begin
        // Only a fresh rising edge counts; a level still high from before
        // the trigger produces no rise and is ignored.
        if (!enable)      w_next_state = IDLE;
        else if (w_rise)  w_next_state = WAIT_FALL;
        else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state  = HOLDOFF;
          w_timeout_evt = 1'b1;
        end
      end
      WAIT_FALL: begin
        // Fall is checked first so it wins a tie with the timeout. The >=
        // also catches a rise taken on the very last window cycle.
        if (!enable) w_next_state = IDLE;
        else if (w_fall) begin
          w_next_state = HOLDOFF;
          w_done_evt   = 1'b1;
        end else if (r_wait_cnt >= WAIT_LAST) begin
          w_next_state  = HOLDOFF;
          w_timeout_evt = 1'b1;
        end
      end
      HOLDOFF: begin
        if (r_period_cnt == PERIOD_LAST) w_next_state = enable ? CLEAR : IDLE;
      end
      default:   w_next_state = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_trigger_nx     = (w_next_state == TRIG);
    w_timer_reset_nx = (w_next_state == IDLE) || (w_next_state == CLEAR);
    w_busy_nx        = (w_next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_period_cnt    <= '0;
      r_trig_cnt      <= '0;
      r_wait_cnt      <= '0;
      r_trigger       <= 1'b0;
      r_timer_reset   <= 1'b1;
      r_busy          <= 1'b0;
      r_meas_done     <= 1'b0;
      r_timeout       <= 1'b0;
      r_shot_count    <= 8'd0;
      r_timeout_count <= 8'd0;
    end else begin
      r_state       <= w_next_state;
      r_trigger     <= w_trigger_nx;
      r_timer_reset <= w_timer_reset_nx;
      r_busy        <= w_busy_nx;
      r_meas_done   <= w_done_evt;
      r_timeout     <= w_timeout_evt;
      if (w_done_evt || w_timeout_evt) r_shot_count <= r_shot_count + 8'd1;
      if (w_timeout_evt) r_timeout_count <= sat_inc8(r_timeout_count);
      // period_cnt holds the number of cycles since CLEAR was entered, so
      // CLEAR-to-CLEAR is exactly PERIOD_CYCLES whatever the echo does.
      if ((w_next_state == CLEAR) || (w_next_state == IDLE)) r_period_cnt <= '0;
      else                                                   r_period_cnt <= r_period_cnt + CNT_ONE;
      if (r_state == TRIG) r_trig_cnt <= r_trig_cnt + CNT_ONE;
      else                 r_trig_cnt <= '0;
      // wait_cnt runs across both wait states; the window covers rise and fall.
      if ((r_state == WAIT_RISE) || (r_state == WAIT_FALL)) r_wait_cnt <= r_wait_cnt + CNT_ONE;
      else                                                  r_wait_cnt <= '0;
    end
  end

  assign trigger_out   = r_trigger;
  assign echo_sync     = w_sync;
  assign timer_reset   = r_timer_reset;
  assign busy          = r_busy;
  assign meas_done     = r_meas_done;
  assign timeout       = r_timeout;
  assign shot_count    = r_shot_count;
  assign timeout_count = r_timeout_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ultrasonic_trigger_sequencer.sv
module tb_ultrasonic_trigger_sequencer;
  import ultrasonic_pkg::*;

  localparam int TRIG = 4;
  localparam int TO   = 20;
  localparam int PER  = 40;
  localparam logic [1:0] K_DONE = 2'b01;
  localparam logic [1:0] K_TO   = 2'b10;

  // Echo pulses are given as [on, off) sample offsets relative to the first
  // sample after the trigger falls; kind/at give the expected event.
  typedef struct {
    int         on0;
    int         off0;
    int         on1;
    int         off1;
    logic [1:0] kind;
    int         at;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       echo_in;
  logic       trigger_out;
  logic       echo_sync;
  logic       timer_reset;
  logic       busy;
  logic       meas_done;
  logic       timeout;
  logic [7:0] shot_count;
  logic [7:0] timeout_count;
  logic [2:0] dbg_state;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [7:0]  exp_shots;
  logic [7:0]  exp_tos;
  int          prev_t0;
  vec_t        vecs[11];

  ultrasonic_trigger_sequencer #(
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TO),
    .PERIOD_CYCLES  (PER),
    .CNT_WIDTH      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .echo_in       (echo_in),
    .trigger_out   (trigger_out),
    .echo_sync     (echo_sync),
    .timer_reset   (timer_reset),
    .busy          (busy),
    .meas_done     (meas_done),
    .timeout       (timeout),
    .shot_count    (shot_count),
    .timeout_count (timeout_count),
    .dbg_state     (dbg_state)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic echo_val(input vec_t v, input int k);
    return ((k >= v.on0) && (k < v.off0)) || ((k >= v.on1) && (k < v.off1));
  endfunction

  // scoreboard: every done/timeout pulse pops one expected {kind, cycle}
  always @(negedge clk) begin
    if (meas_done || timeout) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {timeout, meas_done, cyc[29:0]}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event", {timeout, meas_done, cyc[29:0]}, mon_e);
      end
    end
  end

  task automatic wait_trigger(output int t0, output bit ok, output logic clr);
    ok  = 1'b0;
    clr = 1'b0;
    t0  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (trigger_out) begin
        ok = 1'b1;
        t0 = int'(cyc);
        break;
      end
      clr = timer_reset;
    end
    if (!ok) check("trigger_wait", 32'(trigger_out), 32'd1);
  endtask

  task automatic run_shot(input vec_t v);
    int   t0;
    int   f;
    bit   ok;
    logic clr;
    wait_trigger(t0, ok, clr);
    if (!ok) return;
    check("clear_before_trig", 32'(clr), 32'd1);
    if (prev_t0 >= 0) check("period", 32'(t0 - prev_t0), 32'(PER));
    prev_t0 = t0;
    f = t0 + TRIG;
    exp_q.push_back({v.kind, 30'(f + v.at)});
    exp_shots++;
    if ((v.kind == K_TO) && (exp_tos != 8'hFF)) exp_tos++;
    for (int k = -TRIG; k <= 33; k++) begin
      if (k != -TRIG) @(negedge clk);
      check("trigger_out", 32'(trigger_out), 32'(k < 0));
      check("timer_reset", 32'(timer_reset), 32'd0);
      check("busy", 32'(busy), 32'd1);
      if (k >= -2) check("echo_sync", 32'(echo_sync), 32'(echo_val(v, k - 2)));
      if (k == 25) begin
        check("shot_count", 32'(shot_count), 32'(exp_shots));
        check("timeout_count", 32'(timeout_count), 32'(exp_tos));
      end
      echo_in = echo_val(v, k);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_trigger"}, 32'(trigger_out), 32'd0);
    check({tag, "_echo_sync"}, 32'(echo_sync), 32'd0);
    check({tag, "_timer_reset"}, 32'(timer_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_meas_done"}, 32'(meas_done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_shot_count"}, 32'(shot_count), 32'd0);
    check({tag, "_timeout_count"}, 32'(timeout_count), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int   t0;
    bit   ok;
    logic clr;

    // vector table
    vecs[0] = '{100, 100, 100, 100, K_TO, 20};   // no echo
    vecs[1] = '{5, 15, 100, 100, K_DONE, 18};    // normal pulse
    vecs[2] = '{-4, 3, 8, 12, K_DONE, 15};       // stale high then new pulse
    vecs[3] = '{5, 30, 100, 100, K_TO, 20};      // rises and stays high
    vecs[4] = '{5, 17, 100, 100, K_DONE, 20};    // fall on last window cycle
    for (int i = 5; i < 11; i++) begin
      vecs[i].on0  = int'($urandom_range(0, 10));
      vecs[i].off0 = vecs[i].on0 + int'($urandom_range(2, 12));
      vecs[i].on1  = 100;
      vecs[i].off1 = 100;
      vecs[i].kind = (vecs[i].off0 <= 17) ? K_DONE : K_TO;
      vecs[i].at   = (vecs[i].off0 <= 17) ? vecs[i].off0 + 3 : 20;
    end

    // reset
    reset     = 1'b1;
    enable    = 1'b0;
    echo_in   = 1'b0;
    exp_shots = 8'd0;
    exp_tos   = 8'd0;
    prev_t0   = -1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    foreach (vecs[i]) run_shot(vecs[i]);

    // enable dropped in the second TRIG cycle
    wait_trigger(t0, ok, clr);
    if (ok) begin
      @(negedge clk);
      check("abort_trig_still_high", 32'(trigger_out), 32'd1);
      enable = 1'b0;
      @(negedge clk);
      check("abort_trigger", 32'(trigger_out), 32'd0);
      check("abort_timer_reset", 32'(timer_reset), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(IDLE));
      check("abort_shot_count", 32'(shot_count), 32'(exp_shots));
      check("abort_timeout_count", 32'(timeout_count), 32'(exp_tos));
      repeat (5) @(negedge clk);
      check("abort_stays_idle", 32'(dbg_state), 32'(IDLE));
    end
    prev_t0 = -1;

    // reset asserted while waiting for the echo to fall
    enable = 1'b1;
    wait_trigger(t0, ok, clr);
    if (ok) begin
      repeat (TRIG + 1) @(negedge clk);
      echo_in = 1'b1;
      repeat (4) @(negedge clk);
      check("in_wait_fall", 32'(dbg_state), 32'(WAIT_FALL));
      reset = 1'b1;
      @(negedge clk);
      exp_shots = 8'd0;
      exp_tos   = 8'd0;
      check_reset_values("midshot_reset");
      echo_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
    end
    prev_t0 = -1;

    // saturation / wrap
    for (int n = 0; n < 260; n++) run_shot(vecs[0]);
    check("wrap_shot_count", 32'(shot_count), 32'd4);
    check("sat_timeout_count", 32'(timeout_count), 32'd255);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("final_state", 32'(dbg_state), 32'(IDLE));
    check("final_busy", 32'(busy), 32'd0);
    check("final_timer_reset", 32'(timer_reset), 32'd1);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
